// File: rtl/float_key_pkg.sv
// float_key_pkg: shared float-key widths, loader FSM states and key encode/decode helpers
package float_key_pkg;
  localparam int NK_DEF = 23;
  localparam int M_DEF = 8;
  localparam int L_DEF = NK_DEF + M_DEF + 1;
  typedef enum logic [2:0] {IDLE, FILL, START, SEND, WAIT} state_t;
  // Negatives are fully inverted, positives get the sign bit set, so unsigned key order matches float order
  function automatic logic [L_DEF-1:0] key_encode(input logic [L_DEF-1:0] x);
    return x[L_DEF-1] ? ~x : {1'b1, x[L_DEF-2:0]};
  endfunction
  function automatic logic [L_DEF-1:0] key_decode(input logic [L_DEF-1:0] k);
    return k[L_DEF-1] ? {1'b0, k[L_DEF-2:0]} : ~k;
  endfunction
endpackage

// File: rtl/float_key_enc.sv
// float_key_enc: combinational float-to-sortable-key encoder; FTZ_EN flushes -0 and subnormals to +0 first
//   raw_i : {sign, exp[M], mant[Nk]}
//   key_o : order-preserving unsigned key
module float_key_enc #(
  parameter int Nk = 23,
  parameter int M = 8,
  localparam int L = Nk + M + 1
) (
  input  logic [L-1:0] raw_i,
  output logic [L-1:0] key_o
);
  logic [L-1:0] x;
`ifdef FTZ_EN
  assign x = (raw_i[L-2:Nk] == '0 && (raw_i[Nk-1:0] != '0 || raw_i[L-1])) ? '0 : raw_i;
`else
  assign x = raw_i;
`endif
  assign key_o = x[L-1] ? ~x : {1'b1, x[L-2:0]};
endmodule

// File: rtl/float_key_loader.sv
// float_key_loader: buffers a batch of K float keys from a valid/ready stream and replays it to the sort shell
//   clk, reset (async, high) | in_valid/in_data/in_ready : input stream
//   sort_done : shell finished | start, inp_raw : shell feed | busy, fill_level : status
//   Build option FTZ_EN: flush -0 and subnormals to +0 before mapping.
module float_key_loader import float_key_pkg::*; #(
  parameter int Nk = NK_DEF,
  parameter int M = M_DEF,
  parameter int K = 10,
  localparam int L = Nk + M + 1,
  localparam int S = $clog2(K) + 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  input  logic [L-1:0] in_data,
  output logic         in_ready,
  input  logic         sort_done,
  output logic         start,
  output logic [L-1:0] inp_raw,
  output logic         busy,
  output logic [S-1:0] fill_level
);
  state_t state_q;
  logic in_ready_q, start_q, busy_q, acc;
  logic [L-1:0] inp_raw_q, key;
  logic [S-1:0] wr_ptr_q, rd_ptr_q;
  logic [L-1:0] mem_q [K];
  assign acc = in_valid & in_ready_q;
  assign in_ready = in_ready_q;
  assign start = start_q;
  assign inp_raw = inp_raw_q;
  assign busy = busy_q;
  // The write pointer doubles as the fill level: it is never decremented during SEND
  assign fill_level = wr_ptr_q;
  float_key_enc #(.Nk(Nk), .M(M)) u_enc (.raw_i(in_data), .key_o(key));
  always_ff @(posedge clk)
    if (acc) mem_q[wr_ptr_q[S-2:0]] <= key;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      in_ready_q <= 1'b1;
      start_q <= 1'b0;
      busy_q <= 1'b0;
      inp_raw_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else
      case (state_q)
        IDLE, FILL:
          if (acc) begin
            wr_ptr_q <= wr_ptr_q + S'(1);
            if (wr_ptr_q == S'(K - 1)) begin
              state_q <= START;
              in_ready_q <= 1'b0;
              start_q <= 1'b1;
              busy_q <= 1'b1;
            end else
              state_q <= FILL;
          end
        // Word 0 is issued on leaving START, so rd_ptr already points at word 1 in SEND
        START: begin
          state_q <= SEND;
          start_q <= 1'b0;
          inp_raw_q <= mem_q[0];
          rd_ptr_q <= S'(1);
        end
        SEND:
          if (rd_ptr_q == S'(K)) begin
            state_q <= WAIT;
            inp_raw_q <= '0;
          end else begin
            inp_raw_q <= mem_q[rd_ptr_q[S-2:0]];
            rd_ptr_q <= rd_ptr_q + S'(1);
          end
        WAIT:
          if (sort_done) begin
            state_q <= IDLE;
            in_ready_q <= 1'b1;
            busy_q <= 1'b0;
            wr_ptr_q <= '0;
          end
        default: state_q <= IDLE;
      endcase
endmodule
